maj_seq_eval: RTL

Sequential evaluator for majority-gate netlists of up to 7 primary inputs. One shared 3-input majority unit is time-multiplexed over a programmable list of up to 8 steps, one step per clock. Each step's result goes into a small result file. The controller accepts an input vector through a valid/ready handshake and returns the last step's result through a second valid/ready handshake. It sits beside the combinational classification functions and runs any 5-to-8-gate majority chain without re-synthesis.

---
 rtl/maj_seq_eval_pkg.sv | 42 ++++
 rtl/maj_seq_eval_if.sv | 22 ++
 rtl/maj_seq_eval_maj3_unit.sv | 34 +++
 rtl/maj_seq_eval.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/maj_seq_eval_pkg.sv
// Shared types and constants for the sequential majority-netlist evaluator.
// Operand selects address x0..x6, a constant 0 and the result file r0..r7.
package maj_seq_pkg;

  localparam int N_IN    = 7;
  localparam int N_STEPS = 8;
  localparam int SEL_W   = 4;
  localparam int OP_W    = 5;

  localparam logic [SEL_W-1:0] SEL_X0   = 4'd0;
  localparam logic [SEL_W-1:0] SEL_X1   = 4'd1;
  localparam logic [SEL_W-1:0] SEL_X2   = 4'd2;
  localparam logic [SEL_W-1:0] SEL_X3   = 4'd3;
  localparam logic [SEL_W-1:0] SEL_X4   = 4'd4;
  localparam logic [SEL_W-1:0] SEL_X5   = 4'd5;
  localparam logic [SEL_W-1:0] SEL_X6   = 4'd6;
  localparam logic [SEL_W-1:0] SEL_ZERO = 4'd7;
  localparam logic [SEL_W-1:0] SEL_R0   = 4'd8;

  typedef struct packed {
    logic             inv;
    logic [SEL_W-1:0] sel;
  } operand_t;

  // op2 sits in the most significant bits of the 15-bit step word
  typedef struct packed {
    operand_t op2;
    operand_t op1;
    operand_t op0;
  } step_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/maj_seq_eval_if.sv
// Input-vector and result streams of the evaluator, each a valid/ready pair.
interface maj_seq_eval_if;
  import maj_seq_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] x;
  logic            out_valid;
  logic            out_ready;
  logic            out;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/maj_seq_eval_maj3_unit.sv
// Shared majority unit: resolves three operand fields against x and the
// result file, applies optional inversion and returns MAJ(a,b,c).
module maj3_unit
  import maj_seq_pkg::*;
(
  input  operand_t             op0,
  input  operand_t             op1,
  input  operand_t             op2,
  input  logic [N_IN-1:0]      x,
  input  logic [N_STEPS-1:0]   r,
  output logic                 y
);

  // Select 7 falls on the zero bit padded above x6
  function automatic logic resolve(input operand_t op,
                                   input logic [N_IN-1:0] xv,
                                   input logic [N_STEPS-1:0] rv);
    logic [N_IN:0] xz;
    logic          v;
    xz = {1'b0, xv};
    if (op.sel[3]) begin
      v = rv[op.sel[2:0]];
    end else begin
      v = xz[op.sel[2:0]];
    end
    return v ^ op.inv;
  endfunction

  // Combinational operand mux plus majority vote
  always_comb begin
    y = maj3(resolve(op0, x, r), resolve(op1, x, r), resolve(op2, x, r));
  end

endmodule

// File: rtl/maj_seq_eval.sv
// Time-multiplexed majority-chain evaluator: program memory, result file and
// IDLE/RUN/DONE controller around one shared maj3_unit.
module maj_seq_eval
  import maj_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  maj_seq_eval_if.slave bus,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [14:0] cfg_data,
  input  logic        cfg_len_we,
  input  logic [2:0]  cfg_len,
  output logic        cfg_err,
  output logic        busy
);

  state_t             state_r;
  state_t             state_s;
  step_t              prog_r [N_STEPS];
  logic [2:0]         len_r;
  logic [2:0]         k_r;
  logic [N_IN-1:0]    x_r;
  logic [N_STEPS-1:0] res_r;
  logic               out_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               cfg_err_r;
  logic               accept_s;
  logic               last_step_s;
  logic               step_y_s;
  step_t              cur_step_s;

  assign accept_s    = (state_r == IDLE) && bus.in_valid && in_ready_r;
  assign last_step_s = (k_r == len_r);
  assign cur_step_s  = prog_r[k_r];

  maj3_unit u_maj3 (
    .op0 (cur_step_s.op0),
    .op1 (cur_step_s.op1),
    .op2 (cur_step_s.op2),
    .x   (x_r),
    .r   (res_r),
    .y   (step_y_s)
  );

  // Next-state logic for the controller
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake/status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
      cfg_err_r   <= (cfg_we | cfg_len_we) && (state_r != IDLE);
    end
  end

  // Program memory and length; writes outside IDLE are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STEPS; i++) begin
        prog_r[i] <= '0;
      end
      len_r <= 3'd0;
    end else begin
      if (cfg_we && (state_r == IDLE)) begin
        prog_r[cfg_addr] <= step_t'(cfg_data);
      end
      if (cfg_len_we && (state_r == IDLE)) begin
        len_r <= cfg_len;
      end
    end
  end

  // Datapath: input capture, per-step result write and final result latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r   <= '0;
      res_r <= '0;
      k_r   <= 3'd0;
      out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r   <= bus.x;
            res_r <= '0;
            k_r   <= 3'd0;
          end
        end
        RUN: begin
          res_r[k_r] <= step_y_s;
          k_r        <= k_r + 3'd1;
          if (last_step_s) begin
            out_r <= step_y_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign busy          = busy_r;
  assign cfg_err       = cfg_err_r;

endmodule
